alu_op_issuer: RTL and testbench
================================

// Module: alu_op_issuer
// PURPOSE
//  Command-side initiator for the combinational n-bit ALU. Accepts operation
//  commands on a valid/ready channel and registers the operands onto the ALU
//  input ports. Captures the ALU result and flags, then returns them with the
//  command tag on a valid/ready response channel.
//  Holds an accumulator so that commands can chain on the previous result.
// PARAMETERS
//  NUM_BITS  8  operand/result width; must match the attached ALU
//  TAG_BITS  4  width of the command tag echoed on the response
// PORTS
//  clk          in   1         clock, rising edge
//  rst_n        in   1         reset, asynchronous, active-low
//  cmd_valid    in   1         command present
//  cmd_ready    out  1         issuer can accept a command
//  cmd_opcode   in   4         ALU opcode (0000 add .. 1110 arithmetic shift right)
//  cmd_signed   in   1         signed_mode for this op
//  cmd_a        in   NUM_BITS  operand A
//  cmd_b        in   NUM_BITS  operand B
//  cmd_use_acc  in   1         1: replace cmd_a with the accumulator
//  cmd_tag      in   TAG_BITS  caller tag
//  alu_a        out  NUM_BITS  to ALU A
//  alu_b        out  NUM_BITS  to ALU B
//  alu_opcode   out  4         to ALU opcode
//  alu_signed   out  1         to ALU signed_mode
//  alu_result   in   NUM_BITS  from ALU Result
//  alu_flags    in   4         from ALU {Z,N,C,V}
//  rsp_valid    out  1         response present
//  rsp_ready    in   1         consumer accepts the response
//  rsp_result   out  NUM_BITS  captured result
//  rsp_flags    out  4         captured {Z,N,C,V}
//  rsp_tag      out  TAG_BITS  tag of the originating command
//  rsp_err      out  1         divide error, or illegal opcode 1111
//  acc          out  NUM_BITS  accumulator value
// BEHAVIOUR
//  - Reset: all outputs are 0 and the accumulator is 0. alu_* ports are 0
//    (add 0+0). The FSM is in IDLE, so cmd_ready = 1 after reset.
//  - FSM IDLE -> ISSUE -> RESP -> IDLE.
//  - IDLE: cmd_ready = 1. On cmd_valid & cmd_ready:
//    - alu_a <= cmd_use_acc ? acc : cmd_a
//    - alu_b, alu_opcode and alu_signed are registered from the command.
//    - The tag is latched.
//    - The FSM moves to ISSUE.
//  - ISSUE: alu_* are stable. At the end of the cycle the issuer captures
//    rsp_result <= alu_result and rsp_flags <= alu_flags.
//    - rsp_err <= (opcode==0011 & V) | (opcode==1111)
//    - If rsp_err is 0, acc <= alu_result. If rsp_err is 1, acc is unchanged.
//    - The FSM moves to RESP.
//  - RESP: rsp_valid = 1. All rsp_* outputs are held stable until
//    rsp_valid & rsp_ready. On that handshake the FSM returns to IDLE.
//    - cmd_ready = 0 in ISSUE and RESP. No command is accepted while a
//      response is pending.
//  - Latency: a command accepted at edge k gives rsp_valid = 1 from edge k+2.
//    Minimum spacing between accepted commands is 3 cycles.
//  - alu_* keep their last values in IDLE and do not return to 0.
//  - Opcode 1111 is still driven onto the ALU. The ALU returns Result = 0 and
//    rsp_err = 1.
//  - cmd_use_acc uses the accumulator value at the accept edge.
//  - No widening or truncation: the accumulator is NUM_BITS wide and wraps
//    exactly as the ALU does.
//  - Reset mid-operation (any state) aborts the operation:
//    - the pending command is discarded and no response is produced;
//    - rsp_valid drops asynchronously;
//    - acc is cleared.
// CONFIGURATION
//  ALU_STICKY_FLAGS_EN defined:
//    - Adds port sticky_clr (in, 1) and port sticky_v (out, 1).
//    - sticky_v is set on any capture with V = 1 or rsp_err = 1.
//    - sticky_v is cleared only by sticky_clr, sampled at the clock edge, or
//      by reset. Clear has priority over a simultaneous set.
//  ALU_STICKY_FLAGS_EN undefined: both ports are absent and there is no
//    sticky logic.
// TESTING
//  - Reset while in RESP with rsp_ready = 0:
//    - rsp_valid drops immediately and acc = 0;
//    - after rst_n rises, cmd_ready = 1 and no stale response appears.
//  - Unsigned add, A=200, B=100, tag 3, accepted at edge k:
//    - rsp_valid at k+2;
//    - rsp_result = 44, flags {Z,N,C,V} = 0010, rsp_tag = 3, acc = 44.
//  - Following the add, signed sub with cmd_use_acc = 1, B = 44:
//    - alu_a = 44;
//    - rsp_result = 0, flags Z = 1, acc = 0.
//  - Divide A=10, B=0 with acc = 7 beforehand:
//    - rsp_err = 1, V = 1, rsp_result = 0;
//    - acc remains 7.
//  - Backpressure: rsp_ready held 0 for 5 cycles while cmd_valid = 1:
//    - rsp_* remain stable and cmd_ready = 0 throughout;
//    - the next command is accepted in the cycle after the handshake.
//  - ALU_STICKY_FLAGS_EN, signed add A=100, B=100 (V = 1), then a clean add:
//    - sticky_v = 1 after both operations;
//    - after one cycle of sticky_clr, sticky_v = 0.

Source files
------------

// File: rtl/alu_op_issuer.sv
// -----------------------------------------------------------------------------
// alu_op_issuer
//
// Command-side initiator for a combinational NUM_BITS-wide ALU. A command is
// taken on a valid/ready channel, its operands are registered onto the ALU
// input ports, the ALU result and flags are captured one cycle later, and
// they are returned with the command tag on a valid/ready response channel.
// An accumulator holds the last error-free result so commands can chain.
//
// Optional feature (macro ALU_STICKY_FLAGS_EN):
//   adds sticky_clr (in) / sticky_v (out), a sticky overflow/error flag.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   cmd_valid / cmd_ready      command handshake
//   cmd_opcode, cmd_signed     ALU opcode and signed mode for the command
//   cmd_a, cmd_b               operands
//   cmd_use_acc                1: use the accumulator in place of cmd_a
//   cmd_tag                    caller tag echoed on the response
//   alu_a/alu_b/alu_opcode/alu_signed   registered drive to the ALU
//   alu_result, alu_flags      ALU outputs, flags ordered {Z,N,C,V}
//   rsp_valid / rsp_ready      response handshake
//   rsp_result, rsp_flags      captured ALU result and flags
//   rsp_tag, rsp_err           originating tag; divide error or opcode 1111
//   acc                        accumulator
//   sticky_clr, sticky_v       (ALU_STICKY_FLAGS_EN only)
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready for a command; alu_* hold the last issued operation
// ISSUE  | alu_* stable; ALU result/flags captured at end of cycle
// RESP   | response presented, held until rsp_valid & rsp_ready
// -----------------------------------------------------------------------------
module alu_op_issuer #(
    parameter int NUM_BITS = 8,
    parameter int TAG_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef ALU_STICKY_FLAGS_EN
    input  logic                sticky_clr,
    output logic                sticky_v,
`endif
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [3:0]          cmd_opcode,
    input  logic                cmd_signed,
    input  logic [NUM_BITS-1:0] cmd_a,
    input  logic [NUM_BITS-1:0] cmd_b,
    input  logic                cmd_use_acc,
    input  logic [TAG_BITS-1:0] cmd_tag,
    output logic [NUM_BITS-1:0] alu_a,
    output logic [NUM_BITS-1:0] alu_b,
    output logic [3:0]          alu_opcode,
    output logic                alu_signed,
    input  logic [NUM_BITS-1:0] alu_result,
    input  logic [3:0]          alu_flags,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [NUM_BITS-1:0] rsp_result,
    output logic [3:0]          rsp_flags,
    output logic [TAG_BITS-1:0] rsp_tag,
    output logic                rsp_err,
    output logic [NUM_BITS-1:0] acc
);

    localparam logic [3:0] OP_DIV     = 4'b0011;
    localparam logic [3:0] OP_ILLEGAL = 4'b1111;
    localparam int         FLAG_V     = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic cmd_fire;
    logic rsp_fire;
    logic capture;
    logic err_nxt;

    assign cmd_fire = cmd_valid & cmd_ready;
    assign rsp_fire = rsp_valid & rsp_ready;
    assign capture  = (state == S_ISSUE);

    // Error is judged on the operation actually sitting on the ALU, which is
    // the registered opcode, not whatever the command port shows now.
    assign err_nxt = ((alu_opcode == OP_DIV) & alu_flags[FLAG_V])
                   | (alu_opcode == OP_ILLEGAL);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cmd_fire) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_RESP;
            S_RESP:  if (rsp_fire) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs; rsp_valid falls straight away on async reset
    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            S_IDLE:  cmd_ready = 1'b1;
            S_RESP:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand issue and response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            alu_signed <= 1'b0;
            rsp_tag    <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
            acc        <= '0;
        end else begin
            if (cmd_fire) begin
                alu_a      <= cmd_use_acc ? acc : cmd_a;
                alu_b      <= cmd_b;
                alu_opcode <= cmd_opcode;
                alu_signed <= cmd_signed;
                rsp_tag    <= cmd_tag;
            end
            if (capture) begin
                rsp_result <= alu_result;
                rsp_flags  <= alu_flags;
                rsp_err    <= err_nxt;
                if (!err_nxt) begin
                    acc <= alu_result;
                end
            end
        end
    end

`ifdef ALU_STICKY_FLAGS_EN
    // Clear wins over a set in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_v <= 1'b0;
        end else if (sticky_clr) begin
            sticky_v <= 1'b0;
        end else if (capture && (alu_flags[FLAG_V] || err_nxt)) begin
            sticky_v <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_issuer.sv
module tb_alu_op_issuer;

    localparam int N = 8;
    localparam int T = 4;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_opcode;
    logic         cmd_signed;
    logic [N-1:0] cmd_a;
    logic [N-1:0] cmd_b;
    logic         cmd_use_acc;
    logic [T-1:0] cmd_tag;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_opcode;
    logic         alu_signed;
    logic [N-1:0] alu_result;
    logic [3:0]   alu_flags;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_result;
    logic [3:0]   rsp_flags;
    logic [T-1:0] rsp_tag;
    logic         rsp_err;
    logic [N-1:0] acc;
`ifdef ALU_STICKY_FLAGS_EN
    logic         sticky_clr;
    logic         sticky_v;
`endif

    alu_op_issuer #(.NUM_BITS(N), .TAG_BITS(T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef ALU_STICKY_FLAGS_EN
        .sticky_clr  (sticky_clr),
        .sticky_v    (sticky_v),
`endif
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_signed  (cmd_signed),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_use_acc (cmd_use_acc),
        .cmd_tag     (cmd_tag),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_signed  (alu_signed),
        .alu_result  (alu_result),
        .alu_flags   (alu_flags),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_flags   (rsp_flags),
        .rsp_tag     (rsp_tag),
        .rsp_err     (rsp_err),
        .acc         (acc)
    );

    // Behavioural ALU: returns {result, Z, N, C, V}
    function automatic logic [N+3:0] alu_f(input logic [3:0] op, input logic sg,
                                           input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0]   w;
        logic [N-1:0] r;
        logic         c;
        logic         v;
        w = '0;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'h0: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[N-1:0];
                c = w[N];
                v = sg & (a[N-1] == b[N-1]) & (r[N-1] != a[N-1]);
            end
            4'h1: begin
                r = a - b;
                c = (a < b);
                v = sg & (a[N-1] != b[N-1]) & (r[N-1] != a[N-1]);
            end
            4'h2: r = a * b;
            4'h3: begin
                if (b == '0) begin
                    r = '0;
                    v = 1'b1;
                end else if (sg) begin
                    r = $unsigned($signed(a) / $signed(b));
                end else begin
                    r = a / b;
                end
            end
            4'h4: r = a & b;
            4'h5: r = a | b;
            4'h6: r = a ^ b;
            4'h7: r = ~a;
            4'h8: begin r = {a[N-2:0], 1'b0}; c = a[N-1]; end
            4'h9: begin r = {1'b0, a[N-1:1]}; c = a[0]; end
            4'hE: begin r = {a[N-1], a[N-1:1]}; c = a[0]; end
            4'hF: r = '0;
            default: r = a + 1'b1;
        endcase
        return {r, (r == '0), r[N-1], c, v};
    endfunction

    always_comb {alu_result, alu_flags} = alu_f(alu_opcode, alu_signed, alu_a, alu_b);

    typedef struct {
        int           acc_edge;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [3:0]   op;
        logic         sg;
        logic [N-1:0] result;
        logic [3:0]   flags;
        logic [T-1:0] tag;
        logic         err;
        logic [N-1:0] acc;
    } exp_t;

    exp_t         q[$];
    logic [N-1:0] macc;
    int           checks;
    int           errors;
    int           cyc;
    int           last_hs;
    bit           in_rsp;
    bit           force_rdy;
    logic         rdy_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = force_rdy ? rdy_val : (($urandom % 4) != 0);
        end
    end

    // Monitor: sampled at negedge, so a response seen here is taken by the DUT
    // at the following rising edge (cyc + 1).
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
            end else begin
                if (!in_rsp) begin
                    in_rsp = 1'b1;
                    // accept at edge k -> rsp_valid sampled at edge k+2
                    chk("latency", cyc + 1, q[0].acc_edge + 2);
                    chk("alu_a", alu_a, q[0].a);
                    chk("alu_b", alu_b, q[0].b);
                    chk("alu_op", {alu_signed, alu_opcode}, {q[0].sg, q[0].op});
                end
                chk("rsp_result", rsp_result, q[0].result);
                chk("rsp_flags", rsp_flags, q[0].flags);
                chk("rsp_tag", rsp_tag, q[0].tag);
                chk("rsp_err", rsp_err, q[0].err);
                chk("acc", acc, q[0].acc);
                chk("cmd_ready_busy", cmd_ready, 0);
                if (rsp_ready) begin
                    void'(q.pop_front());
                    in_rsp  = 1'b0;
                    last_hs = cyc + 1;
                end
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic sg, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic ua, input logic [T-1:0] tag,
                        input bit chk_b2b);
        int           n;
        exp_t         e;
        logic [N+3:0] rf;
        n = 0;
        @(negedge clk);
        cmd_opcode  = op;
        cmd_signed  = sg;
        cmd_a       = a;
        cmd_b       = b;
        cmd_use_acc = ua;
        cmd_tag     = tag;
        cmd_valid   = 1'b1;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", {31'd0, cmd_ready}, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        e.acc_edge = cyc + 1;
        e.a        = ua ? macc : a;
        e.b        = b;
        e.op       = op;
        e.sg       = sg;
        rf         = alu_f(op, sg, e.a, b);
        e.result   = rf[N+3:4];
        e.flags    = rf[3:0];
        e.tag      = tag;
        e.err      = ((op == 4'b0011) && rf[0]) || (op == 4'b1111);
        e.acc      = e.err ? macc : e.result;
        macc       = e.acc;
        if (chk_b2b) chk("b2b_accept", e.acc_edge, last_hs + 1);
        q.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_a     = N'($urandom);
        cmd_b     = N'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || rsp_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        checks = 0; errors = 0; last_hs = 0; in_rsp = 1'b0;
        force_rdy = 1'b1; rdy_val = 1'b1; macc = '0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_signed = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_use_acc = 1'b0; cmd_tag = '0;
`ifdef ALU_STICKY_FLAGS_EN
        sticky_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_acc", acc, 0);
        chk("rst_alu", {alu_signed, alu_opcode, alu_a, alu_b}, 0);
        chk("rst_rsp", {rsp_err, rsp_tag, rsp_flags, rsp_result}, 0);
        rst_n = 1'b1;

        // Unsigned add 200+100 -> 44, flags 0010, then signed sub acc-44 -> 0
        send(4'h0, 1'b0, 8'd200, 8'd100, 1'b0, 4'd3, 1'b0);
        drain();
        chk("add_acc_44", acc, 44);
        send(4'h1, 1'b1, 8'd0, 8'd44, 1'b1, 4'd5, 1'b0);
        drain();
        chk("sub_acc_0", acc, 0);

        // Divide by zero leaves acc at 7
        send(4'h0, 1'b0, 8'd3, 8'd4, 1'b0, 4'd1, 1'b0);
        send(4'h3, 1'b0, 8'd10, 8'd0, 1'b0, 4'd2, 1'b0);
        drain();
        chk("div0_acc_7", acc, 7);
        send(4'hF, 1'b0, 8'd9, 8'd9, 1'b1, 4'd6, 1'b0);
        drain();
        chk("illegal_acc_7", acc, 7);

        // Backpressure: response held >= 5 cycles while next command waits
        rdy_val = 1'b0;
        send(4'h2, 1'b0, 8'd7, 8'd9, 1'b0, 4'd9, 1'b0);
        fork
            begin
                repeat (8) @(posedge clk);
                rdy_val = 1'b1;
            end
            send(4'h6, 1'b0, 8'h5A, 8'h0F, 1'b1, 4'd10, 1'b1);
        join
        drain();

        // Reset while in RESP with rsp_ready low
        rdy_val = 1'b0;
        send(4'h0, 1'b1, 8'd20, 8'd30, 1'b0, 4'd11, 1'b0);
        begin
            int n;
            n = 0;
            while (!rsp_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("reach_resp", rsp_valid, 1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_rsp_valid", rsp_valid, 0);
        chk("rstmid_acc", acc, 0);
        q.delete();
        in_rsp = 1'b0;
        macc   = '0;
        @(negedge clk);
        rst_n   = 1'b1;
        rdy_val = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_stale_rsp", rsp_valid, 0);
        end
        chk("post_rst_ready", cmd_ready, 1);

`ifdef ALU_STICKY_FLAGS_EN
        send(4'h0, 1'b1, 8'd100, 8'd100, 1'b0, 4'd1, 1'b0);
        send(4'h0, 1'b0, 8'd1, 8'd2, 1'b0, 4'd2, 1'b0);
        drain();
        chk("sticky_set", sticky_v, 1);
        @(negedge clk);
        sticky_clr = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0;
        chk("sticky_clr", sticky_v, 0);
`endif

        // Randomised traffic with random backpressure
        force_rdy = 1'b0;
        for (int i = 0; i < 60; i++) begin
            send(4'($urandom_range(0, 15)), 1'($urandom), N'($urandom),
                 (($urandom % 5) == 0) ? '0 : N'($urandom),
                 1'($urandom), T'($urandom), 1'b0);
            if (($urandom % 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();
        chk("final_acc", acc, macc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
